// File: rtl/alu_issue_queue_pkg.sv
// rtl/alu_issue_queue_pkg.sv - shared types and opcode encodings for the ALU issue queue
package alu_issue_queue_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [3:0]        rob_idx_t;

  typedef enum logic [5:0] {
    OPT_NONE = 6'd0,
    OPT_ADD  = 6'd1,
    OPT_SUB  = 6'd2,
    OPT_AND  = 6'd3,
    OPT_OR   = 6'd4,
    OPT_XOR  = 6'd5,
    OPT_ADDI = 6'd6,
    OPT_SLL  = 6'd7,
    OPT_BEQ  = 6'd8,
    OPT_BNE  = 6'd9
  } inst_opt_t;

  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;
  localparam word_t ZERO_WORD = '0;

endpackage

// File: rtl/alu_issue_queue_prio_enc.sv
// rtl/alu_issue_queue_prio_enc.sv - lowest-index priority encoder (onehot, index, any-valid)
module rs_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             valid_o,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  assign valid_o  = |req_i;
  // Isolate the lowest set bit with the two's-complement trick.
  assign onehot_o = req_i & (~req_i + N'(1));

  // Scan from the top down so the lowest requesting index wins.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - ALU reservation station with CDB wakeup and single-issue scheduler
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OPT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             dsp_valid,
  input  logic [OPT_W-1:0] dsp_opt,
  input  word_t            dsp_val1,
  input  word_t            dsp_val2,
  input  logic [ROB_W-1:0] dsp_q1,
  input  logic [ROB_W-1:0] dsp_q2,
  input  word_t            dsp_imm,
  input  logic [ROB_W-1:0] dsp_rob_idx,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_src,
  input  word_t            cdb_alu_val,
  input  logic             cdb_lsu_valid,
  input  logic [ROB_W-1:0] cdb_lsu_src,
  input  word_t            cdb_lsu_val,
  input  logic             rob_flush,
  output logic             rs_valid,
  output logic [OPT_W-1:0] rs_opt,
  output word_t            rs_val1,
  output word_t            rs_val2,
  output word_t            rs_imm,
  output logic [ROB_W-1:0] rs_rob_idx
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [OPT_W-1:0]   opt_q  [RS_SIZE];
  logic [OPT_W-1:0]   opt_d  [RS_SIZE];
  word_t              val1_q [RS_SIZE];
  word_t              val1_d [RS_SIZE];
  word_t              val2_q [RS_SIZE];
  word_t              val2_d [RS_SIZE];
  word_t              imm_q  [RS_SIZE];
  word_t              imm_d  [RS_SIZE];
  logic [ROB_W-1:0]   q1_q   [RS_SIZE];
  logic [ROB_W-1:0]   q1_d   [RS_SIZE];
  logic [ROB_W-1:0]   q2_q   [RS_SIZE];
  logic [ROB_W-1:0]   q2_d   [RS_SIZE];
  logic [ROB_W-1:0]   rob_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_d  [RS_SIZE];
  logic [CNT_W-1:0]   count_q, count_d;

  logic               rs_valid_q;
  logic [OPT_W-1:0]   rs_opt_q;
  word_t              rs_val1_q, rs_val2_q, rs_imm_q;
  logic [ROB_W-1:0]   rs_rob_q;

  logic [RS_SIZE-1:0] ready_vec, free_vec, alloc_oh, issue_oh;
  logic [IDX_W-1:0]   alloc_idx, issue_idx;
  logic               free_any, ready_any, accept, issue_fire;

  // Resolve one operand against both CDB ports; ALU port has priority.
  function automatic logic [ROB_W+WORD_W-1:0] snoop(input logic [ROB_W-1:0] tag,
                                                    input word_t val);
    logic [ROB_W+WORD_W-1:0] r;
    r = {tag, val};
    if (tag != '0) begin
      if (cdb_alu_valid && cdb_alu_src == tag)      r = {{ROB_W{1'b0}}, cdb_alu_val};
      else if (cdb_lsu_valid && cdb_lsu_src == tag) r = {{ROB_W{1'b0}}, cdb_lsu_val};
    end
    return r;
  endfunction

  assign rs_full = (count_q == CNT_W'(RS_SIZE));
  assign free_vec = ~busy_q;

  // An entry is issuable once both of its stored tags have been cleared.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req_i(free_vec), .valid_o(free_any), .onehot_o(alloc_oh), .idx_o(alloc_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_enc (
    .req_i(ready_vec), .valid_o(ready_any), .onehot_o(issue_oh), .idx_o(issue_idx)
  );

  // Flush overrides everything; fullness is judged before this cycle's issue.
  assign accept     = dsp_valid && !rs_full && free_any && !rob_flush;
  assign issue_fire = ready_any && !rob_flush;

  // Occupancy and busy-flag next state.
  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (rob_flush) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      if (accept)     busy_d = busy_d | alloc_oh;
      if (issue_fire) busy_d = busy_d & ~issue_oh;
      count_d = count_q + CNT_W'(accept) - CNT_W'(issue_fire);
    end
  end

  // Entry field next state: CDB wakeup for waiting entries, then the new dispatch.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      opt_d[i] = opt_q[i];
      imm_d[i] = imm_q[i];
      rob_d[i] = rob_q[i];
      {q1_d[i], val1_d[i]} = {q1_q[i], val1_q[i]};
      {q2_d[i], val2_d[i]} = {q2_q[i], val2_q[i]};
      if (busy_q[i]) begin
        {q1_d[i], val1_d[i]} = snoop(q1_q[i], val1_q[i]);
        {q2_d[i], val2_d[i]} = snoop(q2_q[i], val2_q[i]);
      end
    end
    if (accept) begin
      opt_d[alloc_idx] = dsp_opt;
      imm_d[alloc_idx] = dsp_imm;
      rob_d[alloc_idx] = dsp_rob_idx;
      {q1_d[alloc_idx], val1_d[alloc_idx]} = snoop(dsp_q1, dsp_val1);
      {q2_d[alloc_idx], val2_d[alloc_idx]} = snoop(dsp_q2, dsp_val2);
    end
  end

  // Entry payload storage; meaningless while the busy flag is clear, so no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        opt_q[i]  <= opt_d[i];
        val1_q[i] <= val1_d[i];
        val2_q[i] <= val2_d[i];
        imm_q[i]  <= imm_d[i];
        q1_q[i]   <= q1_d[i];
        q2_q[i]   <= q2_d[i];
        rob_q[i]  <= rob_d[i];
      end
    end
  end

  // Control state and registered issue bus; data outputs hold when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      count_q    <= '0;
      rs_valid_q <= FALSE;
      rs_opt_q   <= '0;
      rs_val1_q  <= ZERO_WORD;
      rs_val2_q  <= ZERO_WORD;
      rs_imm_q   <= ZERO_WORD;
      rs_rob_q   <= '0;
    end else if (rdy) begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      rs_valid_q <= issue_fire;
      if (issue_fire) begin
        rs_opt_q  <= opt_q[issue_idx];
        rs_val1_q <= val1_q[issue_idx];
        rs_val2_q <= val2_q[issue_idx];
        rs_imm_q  <= imm_q[issue_idx];
        rs_rob_q  <= rob_q[issue_idx];
      end
    end
  end

  assign rs_valid   = rs_valid_q;
  assign rs_opt     = rs_opt_q;
  assign rs_val1    = rs_val1_q;
  assign rs_val2    = rs_val2_q;
  assign rs_imm     = rs_imm_q;
  assign rs_rob_idx = rs_rob_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - self-checking bench for alu_issue_queue
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int N = 16;

  logic        clk, rst, rdy, dsp_valid, rs_full;
  logic [5:0]  dsp_opt, rs_opt;
  logic [31:0] dsp_val1, dsp_val2, dsp_imm, cdb_alu_val, cdb_lsu_val;
  logic [3:0]  dsp_q1, dsp_q2, dsp_rob_idx, cdb_alu_src, cdb_lsu_src, rs_rob_idx;
  logic        cdb_alu_valid, cdb_lsu_valid, rob_flush, rs_valid;
  logic [31:0] rs_val1, rs_val2, rs_imm;

  int checks = 0;
  int failures = 0;

  alu_issue_queue #(.RS_SIZE(N), .ROB_W(4), .OPT_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dsp_valid(dsp_valid), .dsp_opt(dsp_opt), .dsp_val1(dsp_val1), .dsp_val2(dsp_val2),
    .dsp_q1(dsp_q1), .dsp_q2(dsp_q2), .dsp_imm(dsp_imm), .dsp_rob_idx(dsp_rob_idx),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
    .cdb_lsu_valid(cdb_lsu_valid), .cdb_lsu_src(cdb_lsu_src), .cdb_lsu_val(cdb_lsu_val),
    .rob_flush(rob_flush),
    .rs_valid(rs_valid), .rs_opt(rs_opt), .rs_val1(rs_val1), .rs_val2(rs_val2),
    .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain slot array plus the expected issue bus.
  logic        m_busy [N];
  logic [5:0]  m_opt  [N];
  logic [31:0] m_v1 [N], m_v2 [N], m_imm [N];
  logic [3:0]  m_q1 [N], m_q2 [N], m_rob [N];
  logic        e_valid;
  logic [5:0]  e_opt;
  logic [31:0] e_v1, e_v2, e_imm;
  logic [3:0]  e_rob;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic void res(input logic [3:0] q, input logic [31:0] v,
                              output logic [3:0] qo, output logic [31:0] vo);
    qo = q; vo = v;
    if (q != 0 && cdb_alu_valid && cdb_alu_src == q) begin qo = 0; vo = cdb_alu_val; end
    else if (q != 0 && cdb_lsu_valid && cdb_lsu_src == q) begin qo = 0; vo = cdb_lsu_val; end
  endfunction

  task automatic model_clear(input logic zero_out);
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    e_valid = 1'b0;
    if (zero_out) begin e_opt = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_rob = 0; end
  endtask

  task automatic model_step();
    int ri, fi;
    if (rst) begin model_clear(1'b1); return; end
    if (!rdy) return;
    if (rob_flush) begin model_clear(1'b0); return; end
    ri = -1; fi = -1;
    for (int i = 0; i < N; i++) begin
      if (ri < 0 && m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) ri = i;
      if (fi < 0 && !m_busy[i]) fi = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        res(m_q1[i], m_v1[i], m_q1[i], m_v1[i]);
        res(m_q2[i], m_v2[i], m_q2[i], m_v2[i]);
      end
    end
    e_valid = (ri >= 0);
    if (ri >= 0) begin
      e_opt = m_opt[ri]; e_v1 = m_v1[ri]; e_v2 = m_v2[ri];
      e_imm = m_imm[ri]; e_rob = m_rob[ri]; m_busy[ri] = 1'b0;
    end
    if (dsp_valid && fi >= 0) begin
      m_busy[fi] = 1'b1; m_opt[fi] = dsp_opt; m_imm[fi] = dsp_imm; m_rob[fi] = dsp_rob_idx;
      res(dsp_q1, dsp_val1, m_q1[fi], m_v1[fi]);
      res(dsp_q2, dsp_val2, m_q2[fi], m_v2[fi]);
    end
  endtask

  // One clock: check rs_full before the edge, advance the model, compare after.
  task automatic step();
    chk("rs_full_pre", 32'(rs_full), 32'(m_count() == N));
    model_step();
    @(posedge clk); #1;
    chk("m_valid", 32'(rs_valid), 32'(e_valid));
    chk("m_opt", 32'(rs_opt), 32'(e_opt));
    chk("m_val1", rs_val1, e_v1);
    chk("m_val2", rs_val2, e_v2);
    chk("m_imm", rs_imm, e_imm);
    chk("m_rob", 32'(rs_rob_idx), 32'(e_rob));
  endtask

  task automatic clr_in();
    rst = 0; rdy = 1; dsp_valid = 0; rob_flush = 0;
    cdb_alu_valid = 0; cdb_lsu_valid = 0;
  endtask

  task automatic disp(input logic [5:0] o, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [3:0] q1, input logic [3:0] q2, input logic [31:0] im,
                      input logic [3:0] rb);
    dsp_valid = 1; dsp_opt = o; dsp_val1 = v1; dsp_val2 = v2;
    dsp_q1 = q1; dsp_q2 = q2; dsp_imm = im; dsp_rob_idx = rb;
  endtask

  task automatic flush_step();
    clr_in(); rob_flush = 1; step(); clr_in();
  endtask

  typedef struct {
    logic [5:0]  opt;
    logic [31:0] v1, v2;
    logic [3:0]  q1, q2;
    logic [31:0] imm;
    logic [3:0]  rob;
    logic        av; logic [3:0] asrc; logic [31:0] aval;
    logic        lv; logic [3:0] lsrc; logic [31:0] lval;
    logic        exp_valid;
    logic [31:0] exp_v1, exp_v2;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{6'(OPT_ADDI), 32'd5, 32'd0, 4'd0, 4'd0, 32'd3, 4'd2,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd5, 32'd0};
    vecs[1] = '{6'(OPT_ADD), 32'd1, 32'd9, 4'd4, 4'd0, 32'd0, 4'd6,
                1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h80, 1'b1, 32'h80, 32'd9};
    vecs[2] = '{6'(OPT_SUB), 32'd11, 32'd1, 4'd0, 4'd3, 32'd7, 4'd1,
                1'b1, 4'd3, 32'd10, 1'b0, 4'd0, 32'd0, 1'b1, 32'd11, 32'd10};
    vecs[3] = '{6'(OPT_BEQ), 32'd0, 32'd0, 4'd5, 4'd6, 32'h40, 4'd15,
                1'b1, 4'd5, 32'd111, 1'b1, 4'd6, 32'd222, 1'b1, 32'd111, 32'd222};
    vecs[4] = '{6'(OPT_XOR), 32'd0, 32'd0, 4'd2, 4'd0, 32'd0, 4'd3,
                1'b1, 4'd3, 32'd55, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 32'd0};

    clr_in();
    dsp_opt = 0; dsp_val1 = 0; dsp_val2 = 0; dsp_q1 = 0; dsp_q2 = 0; dsp_imm = 0; dsp_rob_idx = 0;
    cdb_alu_src = 0; cdb_alu_val = 0; cdb_lsu_src = 0; cdb_lsu_val = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear(1'b1);
    chk("rst_valid", 32'(rs_valid), 0);
    chk("rst_opt", 32'(rs_opt), 0);
    chk("rst_val1", rs_val1, 0);
    chk("rst_val2", rs_val2, 0);
    chk("rst_imm", rs_imm, 0);
    chk("rst_rob", 32'(rs_rob_idx), 0);
    chk("rst_full", 32'(rs_full), 0);

    // Table: dispatch with optional same-cycle CDB forwarding, issue two cycles later.
    for (int k = 0; k < 5; k++) begin
      clr_in();
      disp(vecs[k].opt, vecs[k].v1, vecs[k].v2, vecs[k].q1, vecs[k].q2, vecs[k].imm, vecs[k].rob);
      cdb_alu_valid = vecs[k].av; cdb_alu_src = vecs[k].asrc; cdb_alu_val = vecs[k].aval;
      cdb_lsu_valid = vecs[k].lv; cdb_lsu_src = vecs[k].lsrc; cdb_lsu_val = vecs[k].lval;
      step();
      chk("vec_t1_valid", 32'(rs_valid), 0);
      clr_in(); step();
      chk("vec_t2_valid", 32'(rs_valid), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        chk("vec_opt", 32'(rs_opt), 32'(vecs[k].opt));
        chk("vec_val1", rs_val1, vecs[k].exp_v1);
        chk("vec_val2", rs_val2, vecs[k].exp_v2);
        chk("vec_imm", rs_imm, vecs[k].imm);
        chk("vec_rob", 32'(rs_rob_idx), 32'(vecs[k].rob));
      end
      step();
      chk("vec_t3_valid", 32'(rs_valid), 0);
      flush_step();
      chk("vec_flush_valid", 32'(rs_valid), 0);
    end

    // Waiting entry woken by an ALU broadcast after several idle cycles.
    clr_in(); disp(6'(OPT_ADD), 32'd0, 32'd7, 4'd3, 4'd0, 32'd0, 4'd8); step(); clr_in();
    repeat (4) begin step(); chk("wait_no_issue", 32'(rs_valid), 0); end
    cdb_alu_valid = 1; cdb_alu_src = 3; cdb_alu_val = 32'd10; step(); clr_in();
    chk("wake_t1_valid", 32'(rs_valid), 0);
    step();
    chk("wake_t2_valid", 32'(rs_valid), 1);
    chk("wake_val1", rs_val1, 32'd10);
    chk("wake_val2", rs_val2, 32'd7);

    // Fill to capacity, reject one more, then drain in index order.
    flush_step();
    for (int k = 0; k < N; k++) begin
      disp(6'(OPT_ADD), 32'd0, 32'd0, 4'd9, 4'd0, 32'(k), 4'((k % 15) + 1)); step();
    end
    chk("full_set", 32'(rs_full), 1);
    disp(6'(OPT_ADDI), 32'd1, 32'd0, 4'd0, 4'd0, 32'hDEAD, 4'd1); step(); clr_in();
    cdb_alu_valid = 1; cdb_alu_src = 9; cdb_alu_val = 32'h99; step(); clr_in();
    chk("full_before_issue", 32'(rs_full), 1);
    for (int k = 0; k < N; k++) begin
      step();
      chk("drain_valid", 32'(rs_valid), 1);
      chk("drain_order", rs_imm, 32'(k));
      if (k == 0) chk("full_drop", 32'(rs_full), 0);
    end
    step();
    chk("drain_done", 32'(rs_valid), 0);

    // Flush with waiting and ready entries plus a colliding dispatch.
    for (int k = 0; k < 5; k++) begin disp(6'(OPT_OR), 0, 0, 4'd12, 4'd0, 32'(k), 4'd4); step(); end
    for (int k = 0; k < 2; k++) begin disp(6'(OPT_OR), 0, 0, 4'd13, 4'd0, 32'(k), 4'd5); step(); end
    clr_in(); cdb_alu_valid = 1; cdb_alu_src = 13; cdb_alu_val = 1; step(); clr_in();
    disp(6'(OPT_ADDI), 32'd1, 32'd0, 4'd0, 4'd0, 32'hBAD, 4'd7); rob_flush = 1; step(); clr_in();
    chk("flush_valid", 32'(rs_valid), 0);
    chk("flush_full", 32'(rs_full), 0);
    cdb_alu_valid = 1; cdb_alu_src = 12; step(); clr_in();
    repeat (3) begin step(); chk("flush_no_issue", 32'(rs_valid), 0); end

    // rdy low freezes issue and wakeup.
    disp(6'(OPT_AND), 32'd3, 32'd0, 4'd6, 4'd0, 32'h61, 4'd9); step();
    disp(6'(OPT_AND), 32'd4, 32'd0, 4'd0, 4'd0, 32'h62, 4'd10); step(); clr_in();
    rdy = 0; cdb_alu_valid = 1; cdb_alu_src = 6; cdb_alu_val = 32'h66;
    repeat (3) begin step(); chk("rdy_hold", 32'(rs_valid), 0); end
    clr_in(); step();
    chk("rdy_resume", 32'(rs_valid), 1);
    chk("rdy_resume_imm", rs_imm, 32'h62);
    step();
    chk("rdy_no_wake", 32'(rs_valid), 0);

    // Reset mid-operation drops pending entries.
    disp(6'(OPT_ADDI), 32'd2, 32'd0, 4'd0, 4'd0, 32'h5, 4'd2); step(); clr_in();
    rst = 1; step(); clr_in();
    chk("midrst_valid", 32'(rs_valid), 0);
    step();
    chk("midrst_no_issue", 32'(rs_valid), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      clr_in();
      if ($urandom_range(0, 1) == 1)
        disp(6'($urandom_range(1, 9)), $urandom, $urandom,
             ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
             ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
             $urandom, 4'($urandom_range(1, 15)));
      cdb_alu_valid = ($urandom_range(0, 1) == 1);
      cdb_alu_src = 4'($urandom_range(1, 15)); cdb_alu_val = $urandom;
      cdb_lsu_valid = ($urandom_range(0, 2) == 0);
      cdb_lsu_src = 4'($urandom_range(1, 15)); cdb_lsu_val = $urandom;
      if (cdb_lsu_src == cdb_alu_src) cdb_lsu_valid = 0;
      rob_flush = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Reservation station and issue scheduler for the integer ALU. Accepts dispatched ALU and branch operations with their operands or ROB tags, snoops the CDB to capture pending operands, and issues at most one ready operation per cycle onto the ALU input bus. Sits between the dispatch stage and the combinational ALU. The ALU's CDB outputs loop back into this block for wakeup.

## Interface
Parameters:
- RS_SIZE, 16: number of entries; power of two, 2..32.
- ROB_W, 4: ROB tag width. Tag 0 is reserved and means "no dependency / value present".
- OPT_W, 6: opcode width; matches the shared INST_OPT type.

Ports (name, direction, width, meaning):
- clk  in  1  clock. One clock domain.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- dsp_valid  in  1  dispatch request.
- dsp_opt  in  OPT_W  operation.
- dsp_val1, dsp_val2  in  32  operand values; meaningful only when the matching tag is 0.
- dsp_q1, dsp_q2  in  ROB_W  producer tags; 0 means the value is present.
- dsp_imm  in  32  immediate.
- dsp_rob_idx  in  ROB_W  destination ROB tag; never 0.
- rs_full  out  1  no free entry; combinational from occupancy.
- cdb_alu_valid  in  1  ALU result broadcast valid.
- cdb_alu_src  in  ROB_W  ALU result tag.
- cdb_alu_val  in  32  ALU result value.
- cdb_lsu_valid  in  1  load result broadcast valid.
- cdb_lsu_src  in  ROB_W  load result tag.
- cdb_lsu_val  in  32  load result value.
- rob_flush  in  1  misprediction flush.
- rs_valid  out  1  issue valid to the ALU.
- rs_opt  out  OPT_W  issued operation.
- rs_val1, rs_val2, rs_imm  out  32  issued operands.
- rs_rob_idx  out  ROB_W  issued destination tag.

All outputs except rs_full are registered.

## Operation
Each entry is in one of three states:
- FREE
- WAIT: at least one tag is nonzero.
- READY: both tags are 0.

Dispatch:
- Accepted when dsp_valid && !rs_full. The entry goes to the lowest-index FREE slot.
- When full, dsp_valid is ignored and no state changes. Full is evaluated before that cycle's issue, so there is no accept into a slot that is being freed.

Dispatch forwarding:
- If dsp_qN matches a valid CDB src in the same cycle, the entry stores that CDB value and writes tag 0.
- The ALU CDB port wins over the LSU CDB port on a tag match; a tag match on both ports does not occur by construction.

Wakeup:
- Every WAIT entry compares both tags against both CDB ports each cycle.
- On a match, the entry latches the value and clears that tag.
- WAIT becomes READY at the next edge.

Issue:
- The lowest-index READY entry is selected.
- Its fields are registered onto the rs_* outputs, and the entry returns to FREE at the same edge.
- With no READY entry, rs_valid=0 and the rs_* data outputs hold their previous values.

Flush:
- rob_flush takes priority over dispatch, wakeup and issue.
- At the next edge all entries become FREE and rs_valid=0.
- A dispatch in the flush cycle is discarded.

rdy=0:
- Entries, outputs and occupancy all hold.
- Dispatch, CDB and flush inputs are ignored.

Reset:
- All entries FREE, occupancy 0.
- rs_valid=0; rs_opt, rs_val1, rs_val2, rs_imm, rs_rob_idx all 0.
- rs_full=0.
- Reset mid-operation discards all entries with no issue.

Occupancy count:
- Width clog2(RS_SIZE)+1.
- Dispatch and issue in the same cycle leave the count unchanged.
- rs_full = (count == RS_SIZE).

## Timing
Latencies:
- Dispatch of a ready operation at cycle t: entry READY at t+1, rs_valid at t+2. The ALU result is on the CDB in t+2, because the ALU is combinational.
- CDB broadcast at cycle t for a waiting entry: READY at t+1, rs_valid at t+2.
- Back-to-back dependent ALU ops therefore issue 2 cycles apart.

Rates and handshake:
- Maximum issue rate is 1 per cycle. The ALU never stalls, so there is no issue backpressure.
- rs_full changes in the cycle after the accept or issue that causes it.
- The dispatcher must sample rs_full in the same cycle it drives dsp_valid.

## Structure
Shared package (the existing utils header):
- WORD type.
- ROB_IDX type.
- INST_OPT type and the OPT_* encodings.
- TRUE/FALSE and ZERO_WORD constants.

Entry storage is a set of per-field arrays plus per-entry busy flags.

One sub-module, rs_prio_enc: a parameterised lowest-index priority encoder (onehot-valid and index out). Instantiated twice, once for free-slot selection and once for ready-slot selection.

## Test plan
- Reset, then dispatch ADDI with val1=5, q1=0, imm=3, rob=2 at cycle 1 → rs_valid=1 at cycle 3 with rs_opt=ADDI, rs_val1=5, rs_imm=3, rs_rob_idx=2; rs_valid=0 at cycle 4.
- Dispatch ADD with q1=3, val2=7, q2=0; hold 4 cycles with no issue; drive cdb_alu_valid with src=3, val=10 at cycle t → rs_valid at t+2 with rs_val1=10, rs_val2=7.
- Dispatch with q1=4 in the same cycle as cdb_lsu_valid with src=4, val=0x80 → entry is ready immediately; rs_valid two cycles after dispatch with rs_val1=0x80.
- Fill all 16 entries with q1=9 pending: rs_full=1; a 17th dispatch is ignored; broadcast tag 9 → 16 issues on consecutive cycles in index order, and rs_full drops the cycle after the first issue.
- With 5 WAIT entries and 2 READY entries, assert rob_flush together with a dispatch → next cycle all entries FREE, rs_valid=0, rs_full=0; that dispatch never issues.
- With a READY entry present, hold rdy=0 for 3 cycles while broadcasting CDB tags → no issue and no wakeup; issue resumes 1 cycle after rdy returns high.
